// File: rtl/audio_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : audio_pkg                                                  |
// | Purpose  : Shared audio-path constants, types and the DAC normaliser.  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package audio_pkg;

    localparam int unsigned FRAME_LEN        = 512;
    localparam int unsigned BCLK_DIV         = 8;
    localparam int unsigned I2S_SLOT_BITS    = 32;
    localparam int unsigned DAC_DATA_BITS    = 24;
    localparam int unsigned INTERP_DATA_BITS = 34;

    localparam int unsigned FRAME_CNT_BITS   = $clog2(FRAME_LEN);
    localparam int unsigned BCLK_PHASE_BITS  = $clog2(BCLK_DIV);
    localparam int unsigned SLOT_IDX_BITS    = $clog2(I2S_SLOT_BITS);

    typedef logic        [DAC_DATA_BITS-1:0]    dac_word_t;
    typedef logic signed [INTERP_DATA_BITS-1:0] interp_word_t;

    typedef struct packed {
        dac_word_t left;
        dac_word_t right;
    } stereo_word_t;

    localparam interp_word_t c_SAT_MAX = 34'sh0_007F_FFFF;
    localparam interp_word_t c_SAT_MIN = 34'sh3_FF80_0000;
    localparam dac_word_t    c_DAC_MAX = 24'h7F_FFFF;
    localparam dac_word_t    c_DAC_MIN = 24'h80_0000;

    // Arithmetic right shift followed by saturation to the DAC word range.
    function automatic dac_word_t normalise(input interp_word_t din,
                                            input logic [3:0]   shift);
        interp_word_t x;
        x = din >>> shift;
        if (x > c_SAT_MAX) begin
            normalise = c_DAC_MAX;
        end else if (x < c_SAT_MIN) begin
            normalise = c_DAC_MIN;
        end else begin
            normalise = x[DAC_DATA_BITS-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_frame_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : i2s_frame_timer                                            |
// | Purpose  : Frame counter, I2S bit/word clocks, load and bit strobes.   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module i2s_frame_timer
    import audio_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    output logic [FRAME_CNT_BITS-1:0] frame_cnt,
    output logic                      load,
    output logic                      bit_strobe,
    output logic                      bclk_out,
    output logic                      lrclk_out
);

    logic [FRAME_CNT_BITS-1:0] r_frame_cnt;
    logic                      r_bclk;
    logic                      r_lrclk;

    // Clocks are registered copies of the counter, so they lag it by one cycle.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_frame_cnt <= '0;
            r_bclk      <= 1'b0;
            r_lrclk     <= 1'b0;
        end else begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_BITS'(1);
            r_bclk      <= r_frame_cnt[BCLK_PHASE_BITS-1];
            r_lrclk     <= r_frame_cnt[FRAME_CNT_BITS-1];
        end
    end

    assign frame_cnt  = r_frame_cnt;
    assign load       = run && (r_frame_cnt == FRAME_CNT_BITS'(FRAME_LEN - 1));
    assign bit_strobe = run && (r_frame_cnt[BCLK_PHASE_BITS-1:0] == '0);
    assign bclk_out   = r_bclk;
    assign lrclk_out  = r_lrclk;

endmodule
`default_nettype wire

// File: rtl/i2s_dac_transmitter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : i2s_dac_transmitter                                        |
// | Purpose  : Normalise/saturate stereo samples and serialise them as I2S.|
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module i2s_dac_transmitter
    import audio_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        din_valid,
    input  logic [INTERP_DATA_BITS-1:0] l_data_in,
    input  logic [INTERP_DATA_BITS-1:0] r_data_in,
    input  logic [3:0]                  gain_shift,
    input  logic                        status_clr,
    output logic                        bclk_out,
    output logic                        lrclk_out,
    output logic                        sdata_out,
    output logic                        underrun,
    output logic                        overrun,
    output logic [15:0]                 test_data
);

    logic [FRAME_CNT_BITS-1:0] w_frame_cnt;
    logic                      w_load;
    logic                      w_bit_strobe;
    logic [SLOT_IDX_BITS-1:0]  w_slot;
    logic                      w_chan;
    logic                      w_data_slot;
    logic                      w_set_underrun;
    logic                      w_set_overrun;
    stereo_word_t              w_norm;

    stereo_word_t              r_hold;
    stereo_word_t              r_shift;
    logic                      r_pending;
    logic                      r_sdata;
    logic                      r_underrun;
    logic                      r_overrun;

    i2s_frame_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .frame_cnt  (w_frame_cnt),
        .load       (w_load),
        .bit_strobe (w_bit_strobe),
        .bclk_out   (bclk_out),
        .lrclk_out  (lrclk_out)
    );

    always_comb begin
        w_norm.left  = normalise(interp_word_t'(l_data_in), gain_shift);
        w_norm.right = normalise(interp_word_t'(r_data_in), gain_shift);
    end

    assign w_slot      = w_frame_cnt[FRAME_CNT_BITS-2:BCLK_PHASE_BITS];
    assign w_chan      = w_frame_cnt[FRAME_CNT_BITS-1];
    assign w_data_slot = (w_slot != '0) && (w_slot <= SLOT_IDX_BITS'(DAC_DATA_BITS));

    assign w_set_underrun = w_load && !r_pending && !din_valid;
    assign w_set_overrun  = run && din_valid && r_pending && !w_load;

    // Shift registers rotate rather than shift: after 24 bits each channel is
    // back to its loaded value, which makes an underrun "reload" free.
    // The load point (count 511) never coincides with a bit strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold    <= '0;
            r_shift   <= '0;
            r_pending <= 1'b0;
            r_sdata   <= 1'b0;
        end else if (!run) begin
            r_shift   <= '0;
            r_pending <= 1'b0;
            r_sdata   <= 1'b0;
        end else begin
            if (din_valid) begin
                r_hold <= w_norm;
            end
            if (w_load) begin
                r_pending <= r_pending && din_valid;
                if (r_pending) begin
                    r_shift <= r_hold;
                end else if (din_valid) begin
                    r_shift <= w_norm;
                end
            end else begin
                if (din_valid) begin
                    r_pending <= 1'b1;
                end
                if (w_bit_strobe) begin
                    if (!w_data_slot) begin
                        r_sdata <= 1'b0;
                    end else if (w_chan) begin
                        r_sdata       <= r_shift.right[DAC_DATA_BITS-1];
                        r_shift.right <= {r_shift.right[DAC_DATA_BITS-2:0],
                                          r_shift.right[DAC_DATA_BITS-1]};
                    end else begin
                        r_sdata      <= r_shift.left[DAC_DATA_BITS-1];
                        r_shift.left <= {r_shift.left[DAC_DATA_BITS-2:0],
                                         r_shift.left[DAC_DATA_BITS-1]};
                    end
                end
            end
        end
    end

    // A set event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= w_set_underrun | (r_underrun & ~status_clr);
            r_overrun  <= w_set_overrun  | (r_overrun  & ~status_clr);
        end
    end

    assign sdata_out = r_sdata;
    assign underrun  = r_underrun;
    assign overrun   = r_overrun;
    assign test_data = {w_frame_cnt, r_pending, r_underrun, r_overrun, 4'b0000};

endmodule
`default_nettype wire

// File: doc/i2s_dac_transmitter.md
# i2s_dac_transmitter

Consumes the 96 kHz interpolated stereo stream from the linear interpolator (34-bit signed per channel, one-cycle `din_valid` strobe), normalises and saturates each channel to 24 bits, and serialises it as a standard I2S stream to the DAC. It also generates the DAC bit clock and word clock from the 49.152 MHz master clock. It sits between the interpolator and the DAC pins and closes the sample-rate path: input samples feed the interpolator, the interpolator feeds this block, and this block drives I2S out.

## Interface
- `FRAME_LEN`, 512: clk cycles per stereo frame (49.152 MHz / 96 kHz).
- `BCLK_DIV`, 8: clk cycles per bit clock period (64 bit clocks per frame).
- `clk`  in  1  master clock, 49.152 MHz; the only clock.
- `reset`  in  1  reset, synchronous and active-high.
- `run`  in  1  enable; low holds the block idle.
- `din_valid`  in  1  one-cycle strobe marking a new stereo sample.
- `l_data_in`, `r_data_in`  in  34  signed interpolator output.
- `gain_shift`  in  4  arithmetic right-shift applied before saturation; valid range 0..10; sampled on `din_valid`.
- `status_clr`  in  1  clears the sticky flags.
- `bclk_out`  out  1  I2S bit clock.
- `lrclk_out`  out  1  I2S word clock; 0 = left channel.
- `sdata_out`  out  1  I2S serial data.
- `underrun`, `overrun`  out  1  sticky status flags.
- `test_data`  out  16  debug bus: `{frame_cnt[8:0], pending, underrun, overrun, 4'b0}`.

## Operation
- **Normalise.** On `din_valid`, each channel is computed as `x = data_in >>> gain_shift` (signed), then saturated to 24 bits:
  - x > 0x7FFFFF → 0x7FFFFF
  - x < -0x800000 → 0x800000
  - otherwise `x[23:0]`
- **Holding register.** The normalised pair is written to the holding register and `pending` is set.
- **Frame counter.** `frame_cnt[8:0]` free-runs 0..511 while `run` is high.
  - `bit_slot = frame_cnt[7:3]`
  - channel = `frame_cnt[8]`
  - bclk phase = `frame_cnt[2]`
- **Load point** (`frame_cnt == 511`):
  - `pending` = 1: load the left/right shift registers from the holding register and clear `pending`.
  - `pending` = 0 and `din_valid` in the same cycle: bypass, loading the new normalised pair directly.
  - `pending` = 0 and no `din_valid`: reload the last sent pair and set `underrun`.
- **Overrun.** `din_valid` while `pending` = 1, other than at the load point, overwrites the holding register and sets `overrun`.
- **Simultaneous load and new sample.** `din_valid` at the load point with `pending` = 1: the old holding value is loaded, the new sample is captured, and `pending` stays 1. No overrun is flagged.
- **Serial format** (per channel, 32 slots):
  - slot 0: 0 (the I2S one-bit delay)
  - slots 1..24: data bits 23..0, MSB first
  - slots 25..31: 0
- **`run` low:** `frame_cnt` = 0, all I2S pins 0, `pending` cleared, shift registers cleared. Sticky flags are retained.
- **`status_clr`:** clears both flags. If a set event occurs in the same cycle, the set wins.

## Timing
- **Reset** (takes precedence over `run`): every output 0, `frame_cnt` = 0, `pending` = 0, holding and shift registers = 0.
- **Registered outputs.** All I2S outputs are registered and reflect the `frame_cnt` value of the previous cycle.
- **`bclk_out`:** low for `frame_cnt[2:0]` = 0..3 and high for 4..7. `sdata_out` and `lrclk_out` change only on `bclk_out` falling edges and are stable across rising edges.
- **`lrclk_out`:** equals `frame_cnt[8]`, so it toggles every 256 clk.
- **Rising `run`:** the first `bclk_out` rising edge occurs 5 clk after `run` rises. The first frame carries the reset or last data; a sample only reaches `sdata_out` after it has passed through the load point at cycle 511.
- **Latency:** `din_valid` to its left MSB on `sdata_out` is at most 512 + 9 clk.
- **Status flags:** set in the cycle after the triggering event.

## Structure
- **Shared package** `audio_pkg`: `FRAME_LEN`, `BCLK_DIV`, `I2S_SLOT_BITS` = 32, `DAC_DATA_BITS` = 24, `INTERP_DATA_BITS` = 34.
- **Sub-module** `i2s_frame_timer`: contains the frame counter, `bclk_out`/`lrclk_out` generation, and the `load` and `bit_strobe` pulses.
- **Top level:** normalise/saturate logic, holding register, flags, shift/serialise logic.

## Test plan
1. **Normal transfer.** Stimulus: `gain_shift` = 7, `l_data_in` = 0x91A2B00, `r_data_in` = -128 (all ones above bit 6), one `din_valid` per 512 clk. Required: left word 0x123456, right word 0xFFFFFF; MSB in slot 1, 7 trailing zeros.
2. **Saturation.** Stimulus: `gain_shift` = 7, `l_data_in` = 2^32, `r_data_in` = -2^32. Required: left 0x7FFFFF, right 0x800000.
3. **Underrun.** Stimulus: stop `din_valid` after one sample. Required: the same pair repeats each frame and `underrun` is set at the first missed load point; `status_clr` clears it.
4. **Overrun.** Stimulus: two `din_valid` strobes 100 clk apart within one frame. Required: `overrun` is set and the second sample is transmitted.
5. **Load-point collision.** Stimulus: `din_valid` exactly at `frame_cnt` = 511, once with `pending` = 0 and once with `pending` = 1. Required: with `pending` = 0 the new sample is sent immediately; with `pending` = 1 the old sample is sent, the new one follows next frame, and no flags are set.
6. **Reset / run mid-frame.** Stimulus: assert `reset` at `frame_cnt` = 300, then separately drop `run` at the same point. Required: reset forces outputs and flags to 0 on the next clk; dropping `run` idles the pins while flags are kept. After restart, `bclk_out` has an 8-clk period and `lrclk_out` a 512-clk period.
